vga_line_fetch: RTL and testbench
=================================

Name: vga_line_fetch

Overview:
Scanline prefetcher between the data memory port and the VGA pixel output path. It fetches one line of 1-bpp framebuffer words from dmem into a ping-pong line buffer ahead of display, using a req/gnt handshake with the memory address mux. It then streams pixels MSB-first from the front buffer on each pixel enable. This keeps video reads out of active-video cycles, so ARM data accesses only contend during fetch bursts.

Parameters:
FB_BASE, 32'h0000_0400, byte address of pixel (0,0) word
H_ACTIVE, 640, visible pixels per line (multiple of 32)
V_ACTIVE, 480, visible lines per frame
WORDS, H_ACTIVE/32, words per line (derived; not overridden)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pix_en  in  1  one-cycle pixel strobe (VGA pixel rate)
de  in  1  display enable, active region, qualified by pix_en
line_start  in  1  one-cycle pulse at start of hblank preceding visible line line_y
line_y  in  10  visible line about to be displayed, valid with line_start
frame_start  in  1  one-cycle pulse in vblank before line 0
mem_req  out  1  fetch request
mem_addr  out  32  word-aligned byte address of request
mem_gnt  in  1  grant; mem_rdata valid in the same cycle
mem_rdata  in  32  read data
pix_out  out  1  current pixel bit
line_ready  out  1  back buffer holds complete next line
underrun  out  1  sticky: line_start arrived before fetch completed

Behaviour:
- Reset (synchronous, priority over all inputs): mem_req=0, mem_addr=0, pix_out=0, line_ready=0, underrun=0, FSM=IDLE, front select=0, word index=0, x=0. Buffer contents are don't-care.
- FSM states IDLE, FETCH.
  - IDLE -> FETCH on a fetch trigger: load target line L, word index=0, line_ready=0.
  - FETCH: mem_req=1, mem_addr=FB_BASE + (L*WORDS + idx)*4. Address stays stable while gnt=0.
  - On gnt: write mem_rdata into back[idx]. If idx==WORDS-1, go to IDLE and set line_ready=1; otherwise idx++.
  - mem_req drops in the cycle after the final grant.
- Triggers:
  - frame_start: fetch L=0.
  - line_start with line_y=n:
    - swap front/back.
    - x=0.
    - line_ready=0.
    - fetch L=n+1 if n+1<V_ACTIVE, else stay IDLE.
- line_start while FETCH, or while line_ready=0 with a fetch pending: set underrun=1. Swap anyway, so the stale or partial line is displayed. Abort the current fetch and restart at idx=0 for the new L.
- frame_start and line_start in the same cycle: frame_start wins; no swap.
- Pixel path:
  - On pix_en&&de: pix_out <= front[x>>5][31-(x&31)] (registered, latency 1 clk), then x++.
  - On pix_en&&!de: pix_out <= 0.
  - x saturates at H_ACTIVE-1; extra de strobes repeat the last pixel.
  - pix_out holds its value between strobes.
- Buffer reads and writes target different halves, so there is no read/write hazard. A swap takes effect on the cycle after line_start.
- line_y >= V_ACTIVE on line_start: swap, no fetch.
- underrun is cleared only by reset.

Decomposition:
- Package vga_fetch_pkg: H_ACTIVE, V_ACTIVE, WORDS_PER_LINE, FB_BASE default, FSM state enum (IDLE, FETCH).
- One sub-module, line_buf_2x: two WORDS x 32 arrays with write port (sel, idx, data, we) and read port (sel, idx); inferred RAM or registers.

Test Plan:
- Reset mid-FETCH (idx=7) -> next cycle mem_req=0, line_ready=0, pix_out=0, underrun=0.
- frame_start, gnt always 1, mem_rdata=idx -> 20 requests at addresses 0x400,0x404,...,0x44C; line_ready=1 one cycle after the 20th grant; mem_req low afterwards.
- Grant stall: gnt low 5 cycles at idx=3 -> mem_addr stays 0x40C and no write occurs; on gnt, word 3 is captured correctly.
- line_start y=0 after line 0 is loaded with word0=0x8000_0001 -> 32 de strobes give pix_out 1,0,...,0,1 (each 1 clk after its strobe); fetch of line 1 starts at 0x450.
- line_start y=1 while line 1 fetch stalled at idx=10 -> underrun=1, swap occurs, fetch of line 2 restarts at 0x4A0.
- line_start y=479 -> no mem_req. frame_start coincident with line_start -> fetch of line 0 begins, front select unchanged.

Source files
------------

// File: rtl/vga_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_fetch_pkg
// Brief   : Shared constants, FSM state type and address helper for the VGA
//           scanline prefetcher.
// Revision: 1.0 - initial release
// ============================================================================
package vga_fetch_pkg;

    localparam int          c_h_active       = 640;
    localparam int          c_v_active       = 480;
    localparam int          c_words_per_line = c_h_active / 32;
    localparam logic [31:0] c_fb_base        = 32'h0000_0400;

    // Fetch engine states; explicit one-bit encoding.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } fetch_state_t;

    // Byte address of word idx within the given framebuffer line.
    function automatic logic [31:0] fb_word_addr(
        input logic [31:0] base,
        input logic [31:0] line,
        input logic [31:0] idx,
        input logic [31:0] words
    );
        return base + ((line * words + idx) << 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_line_fetch_line_buf_2x.sv
`default_nettype none
// ============================================================================
// Module  : line_buf_2x
// Brief   : Ping-pong line buffer: two banks of WORDS x 32 bits. Synchronous
//           write port, combinational read port; the bank select of each
//           port picks which half is accessed.
// Revision: 1.0 - initial release
// ============================================================================
module line_buf_2x #(
    parameter int WORDS = 20,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic             i_wr_sel,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [31:0]      i_wr_data,
    input  logic             i_rd_sel,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [31:0]      o_rd_data
);

    logic [31:0] r_mem [2][WORDS];

    // Capture a fetched word into the selected bank.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_sel][i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_sel][i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/vga_line_fetch.sv
`default_nettype none
// ============================================================================
// Module  : vga_line_fetch
// Brief   : Scanline prefetcher. Fetches one line of 1-bpp framebuffer words
//           into the back half of a ping-pong buffer during blanking and
//           streams pixels MSB-first from the front half on each pixel strobe.
// Revision: 1.0 - initial release
// ============================================================================
module vga_line_fetch
    import vga_fetch_pkg::*;
#(
    parameter logic [31:0] FB_BASE  = c_fb_base,
    parameter int          H_ACTIVE = c_h_active,
    parameter int          V_ACTIVE = c_v_active
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        de,
    input  logic        line_start,
    input  logic [9:0]  line_y,
    input  logic        frame_start,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata,
    output logic        pix_out,
    output logic        line_ready,
    output logic        underrun
);

    localparam int                 c_words    = H_ACTIVE / 32;
    localparam int                 c_idx_w    = (c_words > 1) ? $clog2(c_words) : 1;
    localparam int                 c_x_w      = $clog2(H_ACTIVE);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(c_words - 1);
    localparam logic [c_x_w-1:0]   c_x_last   = c_x_w'(H_ACTIVE - 1);
    localparam logic [10:0]        c_v_limit  = 11'(V_ACTIVE);

    // Registered state
    fetch_state_t       r_state;
    logic [9:0]         r_line;
    logic [c_idx_w-1:0] r_idx;
    logic               r_front;
    logic               r_line_ready;
    logic               r_underrun;
    logic [c_x_w-1:0]   r_x;
    logic               r_pix;

    // Next-state values
    fetch_state_t       w_state_nxt;
    logic [9:0]         w_line_nxt;
    logic [c_idx_w-1:0] w_idx_nxt;
    logic               w_front_nxt;
    logic               w_line_ready_nxt;
    logic               w_underrun_nxt;
    logic               w_x_clr;
    logic               w_buf_we;
    logic [10:0]        w_next_line;
    logic [31:0]        w_rd_word;
    logic [c_idx_w-1:0] w_rd_idx;

    // Control register: FSM state, fetch target and buffer bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_line       <= '0;
            r_idx        <= '0;
            r_front      <= 1'b0;
            r_line_ready <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_line       <= w_line_nxt;
            r_idx        <= w_idx_nxt;
            r_front      <= w_front_nxt;
            r_line_ready <= w_line_ready_nxt;
            r_underrun   <= w_underrun_nxt;
        end
    end

    // Next-state logic. frame_start outranks line_start; a trigger aborts any
    // fetch in flight and suppresses that cycle's buffer write so a late grant
    // cannot land in the half that is about to become visible.
    always_comb begin
        w_state_nxt      = r_state;
        w_line_nxt       = r_line;
        w_idx_nxt        = r_idx;
        w_front_nxt      = r_front;
        w_line_ready_nxt = r_line_ready;
        w_underrun_nxt   = r_underrun;
        w_x_clr          = 1'b0;
        w_buf_we         = 1'b0;
        w_next_line      = {1'b0, line_y} + 11'd1;

        if (frame_start) begin
            w_state_nxt      = FETCH;
            w_line_nxt       = '0;
            w_idx_nxt        = '0;
            w_line_ready_nxt = 1'b0;
        end else if (line_start) begin
            w_front_nxt      = ~r_front;
            w_x_clr          = 1'b1;
            w_line_ready_nxt = 1'b0;
            w_idx_nxt        = '0;
            if (r_state == FETCH) begin
                w_underrun_nxt = 1'b1;
            end
            if (w_next_line < c_v_limit) begin
                w_state_nxt = FETCH;
                w_line_nxt  = w_next_line[9:0];
            end else begin
                w_state_nxt = IDLE;
            end
        end else if (r_state == FETCH && mem_gnt) begin
            w_buf_we = 1'b1;
            if (r_idx == c_idx_last) begin
                w_state_nxt      = IDLE;
                w_line_ready_nxt = 1'b1;
            end else begin
                w_idx_nxt = r_idx + c_idx_w'(1);
            end
        end
    end

    assign mem_req  = (r_state == FETCH);
    assign mem_addr = mem_req ? fb_word_addr(FB_BASE, 32'(r_line), 32'(r_idx), 32'(c_words))
                              : 32'h0;

    assign w_rd_idx = c_idx_w'(r_x >> 5);

    line_buf_2x #(
        .WORDS (c_words),
        .IDX_W (c_idx_w)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_en   (w_buf_we),
        .i_wr_sel  (~r_front),
        .i_wr_idx  (r_idx),
        .i_wr_data (mem_rdata),
        .i_rd_sel  (r_front),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_word)
    );

    // Pixel path: bit 31-(x mod 32) of the front word equals index ~x[4:0];
    // x saturates on the last visible pixel so extra strobes repeat it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix <= 1'b0;
            r_x   <= '0;
        end else begin
            if (pix_en) begin
                r_pix <= de ? w_rd_word[~r_x[4:0]] : 1'b0;
            end
            if (w_x_clr) begin
                r_x <= '0;
            end else if (pix_en && de && r_x != c_x_last) begin
                r_x <= r_x + c_x_w'(1);
            end
        end
    end

    assign pix_out    = r_pix;
    assign line_ready = r_line_ready;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_line_fetch
// Brief   : Scoreboard bench for vga_line_fetch. Stimulus pushes expected
//           request addresses and pixels into queues; a monitor pops and
//           compares on each grant and each pixel strobe result.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_line_fetch;

    localparam logic [31:0] c_base  = 32'h0000_0400;
    localparam int          c_words = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        de;
    logic        line_start;
    logic [9:0]  line_y;
    logic        frame_start;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [31:0] mem_rdata;
    logic        pix_out;
    logic        line_ready;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    logic [31:0] addr_q[$];
    logic        pix_q[$];
    logic        pend_pix = 1'b0;
    logic        last_pix = 1'b0;
    logic        hold_chk = 1'b0;

    vga_line_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .de          (de),
        .line_start  (line_start),
        .line_y      (line_y),
        .frame_start (frame_start),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_gnt     (mem_gnt),
        .mem_rdata   (mem_rdata),
        .pix_out     (pix_out),
        .line_ready  (line_ready),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    // Framebuffer model: word (0,0) is 0x8000_0001, others encode their address.
    function automatic logic [31:0] fb_model(input logic [31:0] a);
        if (a == c_base) return 32'h8000_0001;
        return {a[15:0], 16'h0F0F};
    endfunction

    function automatic logic pix_model(input int line, input int x);
        logic [31:0] w;
        w = fb_model(c_base + 32'(line * c_words * 4 + (x / 32) * 4));
        return w[31 - (x % 32)];
    endfunction

    // Read data is garbage whenever no grant is given.
    assign mem_rdata = mem_gnt ? fb_model(mem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input int line);
        for (int i = 0; i < c_words; i++) begin
            addr_q.push_back(c_base + 32'(line * c_words * 4 + i * 4));
        end
    endtask

    // n strobes with de=1 separated by idle cycles; optional de=0 strobe.
    task automatic stream(input int line, input int n, input bit with_gap);
        int x;
        x = 0;
        hold_chk = 1'b1;
        for (int i = 0; i < n; i++) begin
            pix_en = 1'b1; de = 1'b1;
            pix_q.push_back(pix_model(line, x));
            step();
            pix_en = 1'b0; de = 1'b0;
            step();
            if (x < 639) x++;
            if (with_gap && i == 5) begin
                pix_en = 1'b1; de = 1'b0;
                pix_q.push_back(1'b0);
                step();
                pix_en = 1'b0;
                step();
            end
        end
        step();
        hold_chk = 1'b0;
    endtask

    // Monitor: compare granted addresses and registered pixels.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req && mem_gnt) begin
                if (addr_q.size() == 0) begin
                    check("unexpected_grant", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    check("grant_addr", mem_addr, addr_q.pop_front());
                end
            end
            if (pend_pix) begin
                if (pix_q.size() == 0) begin
                    check("unexpected_pixel", 32'(pix_out), 32'hFFFF_FFFF);
                end else begin
                    last_pix = pix_q.pop_front();
                    check("pixel", 32'(pix_out), 32'(last_pix));
                end
            end else if (hold_chk) begin
                check("pixel_hold", 32'(pix_out), 32'(last_pix));
            end
            pend_pix = pix_en;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; pix_en = 1'b0; de = 1'b0; line_start = 1'b0;
        line_y = '0; frame_start = 1'b0; mem_gnt = 1'b0;
        repeat (3) step();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_pix_out", 32'(pix_out), 0);
        check("rst_line_ready", 32'(line_ready), 0);
        check("rst_underrun", 32'(underrun), 0);
        reset = 1'b0;
        step();

        // Line 0 fetch with a five-cycle stall on word 3.
        frame_start = 1'b1;
        push_line(0);
        step();
        frame_start = 1'b0;
        mem_gnt = 1'b1;
        check("fetch0_req", 32'(mem_req), 1);
        check("fetch0_addr0", mem_addr, 32'h400);
        repeat (3) step();
        mem_gnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_addr", mem_addr, 32'h40C);
            step();
        end
        mem_gnt = 1'b1;
        repeat (17) step();
        check("fetch0_ready", 32'(line_ready), 1);
        check("fetch0_req_low", 32'(mem_req), 0);
        check("fetch0_all_granted", 32'(addr_q.size()), 0);
        repeat (2) step();
        check("fetch0_ready_hold", 32'(line_ready), 1);
        mem_gnt = 1'b0;

        // Display line 0 while line 1 fetch stalls at its first word.
        line_y = 10'd0;
        line_start = 1'b1;
        push_line(1);
        step();
        line_start = 1'b0;
        check("ls0_req", 32'(mem_req), 1);
        check("ls0_addr", mem_addr, 32'h450);
        check("ls0_ready_clr", 32'(line_ready), 0);
        check("ls0_underrun", 32'(underrun), 0);
        stream(0, 642, 1'b1);

        // Ten words of line 1, then a premature line_start.
        mem_gnt = 1'b1;
        repeat (10) step();
        mem_gnt = 1'b0;
        check("fetch1_idx10_addr", mem_addr, 32'h478);
        line_y = 10'd1;
        line_start = 1'b1;
        addr_q.delete();
        push_line(2);
        step();
        line_start = 1'b0;
        check("ls1_underrun", 32'(underrun), 1);
        check("ls1_restart_addr", mem_addr, 32'h4A0);
        check("ls1_ready", 32'(line_ready), 0);
        stream(1, 32, 1'b0);
        mem_gnt = 1'b1;
        repeat (20) step();
        mem_gnt = 1'b0;
        check("fetch2_ready", 32'(line_ready), 1);
        check("fetch2_req_low", 32'(mem_req), 0);
        check("fetch2_all_granted", 32'(addr_q.size()), 0);

        // Last visible line: swap, no fetch.
        line_y = 10'd479;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        check("ls479_req", 32'(mem_req), 0);
        check("ls479_ready", 32'(line_ready), 0);
        repeat (3) step();
        check("ls479_req_later", 32'(mem_req), 0);
        check("ls479_addr", mem_addr, 0);

        // frame_start coincident with line_start: fetch line 0, no swap.
        line_y = 10'd5;
        line_start = 1'b1;
        frame_start = 1'b1;
        push_line(0);
        step();
        line_start = 1'b0;
        frame_start = 1'b0;
        check("coinc_req", 32'(mem_req), 1);
        check("coinc_addr", mem_addr, 32'h400);
        stream(2, 32, 1'b0);

        // Reset in the middle of a fetch.
        mem_gnt = 1'b1;
        repeat (7) step();
        mem_gnt = 1'b0;
        check("pre_rst_addr", mem_addr, 32'h41C);
        check("pre_rst_pix", 32'(pix_out), 1);
        reset = 1'b1;
        step();
        addr_q.delete();
        check("midrst_mem_req", 32'(mem_req), 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_line_ready", 32'(line_ready), 0);
        check("midrst_pix_out", 32'(pix_out), 0);
        check("midrst_underrun", 32'(underrun), 0);
        reset = 1'b0;
        repeat (2) step();
        check("pix_q_drained", 32'(pix_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
